// File: rtl/bl_axil_slave_regs.sv
// AXI4-Lite register bank exposing the Bendlab sample word, its sample count and a level IRQ.
// The register bank captures a new sample whenever the live word differs from the last snapshot.
module bl_axil_slave_regs #(
  parameter int unsigned ADDR_W   = 9,
  parameter logic [31:0] ID_VALUE = 32'h424C_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic [31:0]       bl_data_i,
  output logic              irq_o
);

  localparam int unsigned IW = ADDR_W - 2;
  localparam logic [IW-1:0] REG_ID      = IW'(0);
  localparam logic [IW-1:0] REG_CTRL    = IW'(1);
  localparam logic [IW-1:0] REG_STATUS  = IW'(2);
  localparam logic [IW-1:0] REG_DATA    = IW'(3);
  localparam logic [IW-1:0] REG_CNT     = IW'(4);
  localparam logic [IW-1:0] REG_SCRATCH = IW'(5);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  // Write channel holding registers
  logic              aw_held_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic              w_held_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;

  // Read channel registers
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;

  // Register bank
  logic [1:0]        ctrl_q;
  logic [1:0]        status_q;
  logic [1:0]        status_d;
  logic [31:0]       data_q;
  logic [31:0]       cnt_q;
  logic [31:0]       scratch_q;
  logic [31:0]       scratch_d;
  logic [31:0]       d1_q;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [IW-1:0]     wr_idx;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              wr_mapped;
  logic              ctrl_we;
  logic              scratch_we;
  logic [1:0]        status_w1c;
  logic              sample_ev;
  logic [IW-1:0]     rd_idx;
  logic [31:0]       rd_data_c;
  logic              rd_err_c;

  // Readies are forced low while reset is held so nothing is accepted during reset.
  assign s_axi_awready = ~rst & ~aw_held_q & ~bvalid_q;
  assign s_axi_wready  = ~rst & ~w_held_q & ~bvalid_q;
  assign s_axi_arready = ~rst & ~rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign irq_o         = ctrl_q[1] & status_q[0];

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // A write commits as soon as both halves are available, held or arriving this cycle.
  assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_addr = aw_held_q ? aw_addr_q : s_axi_awaddr;
  assign wr_data = w_held_q ? w_data_q : s_axi_wdata;
  assign wr_strb = w_held_q ? w_strb_q : s_axi_wstrb;
  assign wr_idx  = wr_addr[ADDR_W-1:2];

  assign wr_mapped  = (wr_idx <= REG_SCRATCH);
  assign ctrl_we    = commit & (wr_idx == REG_CTRL) & wr_strb[0];
  assign scratch_we = commit & (wr_idx == REG_SCRATCH);
  assign status_w1c = (commit && (wr_idx == REG_STATUS) && wr_strb[0]) ? wr_data[1:0] : 2'b00;

  // Event uses the registered capture_en, so a same-cycle CTRL write does not affect it.
  assign sample_ev = ctrl_q[0] & (d1_q != data_q);

  always_comb begin
    status_d    = status_q & ~status_w1c;
    status_d[0] = status_d[0] | sample_ev;
    status_d[1] = status_d[1] | (sample_ev & status_q[0]);
  end

  always_comb begin
    scratch_d = scratch_q;
    if (scratch_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          scratch_d[8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_idx = s_axi_araddr[ADDR_W-1:2];

  always_comb begin
    rd_data_c = '0;
    rd_err_c  = 1'b0;
    case (rd_idx)
      REG_ID:      rd_data_c = ID_VALUE;
      REG_CTRL:    rd_data_c = {30'd0, ctrl_q};
      REG_STATUS:  rd_data_c = {30'd0, status_q};
      REG_DATA:    rd_data_c = data_q;
      REG_CNT:     rd_data_c = cnt_q;
      REG_SCRATCH: rd_data_c = scratch_q;
      default:     rd_err_c  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          aw_addr_q <= s_axi_awaddr;
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          w_data_q <= s_axi_wdata;
          w_strb_q <= s_axi_wstrb;
        end
        if (bvalid_q && s_axi_bready) begin
          bvalid_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data_c;
      rresp_q  <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      status_q  <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      scratch_q <= '0;
      d1_q      <= '0;
    end else begin
      d1_q      <= bl_data_i;
      status_q  <= status_d;
      scratch_q <= scratch_d;
      if (ctrl_we) begin
        ctrl_q <= wr_data[1:0];
      end
      if (sample_ev) begin
        data_q <= d1_q;
        cnt_q  <= cnt_q + 32'd1;
      end
    end
  end

endmodule
